// File: rtl/ucpd_tx_arbiter.sv
// UCPD transmit scheduler: picks hard reset / cable reset / message, enforces the interframe gap,
// then owns the core's transmit enable for one frame. Optional hard-reset preemption: UCPD_TXARB_PREEMPT_EN.
module ucpd_tx_arbiter #(
  parameter int GAP_W = 5
) (
  input  logic             ic_clk,
  input  logic             ic_rst,
  input  logic             ucpden,
  input  logic             hrst_req,
  input  logic             crst_req,
  input  logic             msg_req,
  input  logic [1:0]       msg_mode,
  input  logic [GAP_W-1:0] ifrgap,
  input  logic             bit_clk_red,
  input  logic             rx_busy,
  input  logic             rx_hrst_det,
  input  logic             tx_done,
  output logic             transmit_en,
  output logic             tx_hrst,
  output logic [1:0]       tx_mode,
  output logic             txsend_clr,
  output logic             txhrst_clr,
  output logic             msg_disc,
  output logic             hrst_disc,
  output logic             busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GAP   = 3'd1;
  localparam logic [2:0] ST_TX    = 3'd2;
`ifdef UCPD_TXARB_PREEMPT_EN
  localparam logic [2:0] ST_ABORT = 3'd3;
`endif
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Source encoding doubles as priority: a larger value wins.
  localparam logic [1:0] SEL_MSG  = 2'd0;
  localparam logic [1:0] SEL_CRST = 2'd1;
  localparam logic [1:0] SEL_HRST = 2'd2;

  logic [2:0]       state, state_nx;
  logic [1:0]       sel, sel_nx;
  logic [1:0]       mode_q, mode_nx;
  logic [GAP_W-1:0] gap_cnt;
  logic             rx_busy_q;
  logic             req_any, sel_live, rx_rise, rx_fall;
  logic [1:0]       req_top;
  logic             en_nx, send_clr_nx, hrst_clr_nx, msg_disc_nx, hrst_disc_nx;
  logic [1:0]       tx_mode_nx;
`ifdef UCPD_TXARB_PREEMPT_EN
  logic             hrst_req_q;
  logic             hrst_rise;

  assign hrst_rise = hrst_req & ~hrst_req_q;
`endif

  assign req_any = hrst_req | crst_req | msg_req;
  assign req_top = hrst_req ? SEL_HRST : (crst_req ? SEL_CRST : SEL_MSG);
  assign sel_live = (sel == SEL_HRST) ? hrst_req : ((sel == SEL_CRST) ? crst_req : msg_req);
  assign rx_rise = rx_busy & ~rx_busy_q;
  assign rx_fall = ~rx_busy & rx_busy_q;

  always_comb begin
    state_nx     = state;
    sel_nx       = sel;
    mode_nx      = mode_q;
    send_clr_nx  = 1'b0;
    hrst_clr_nx  = 1'b0;
    msg_disc_nx  = 1'b0;
    hrst_disc_nx = 1'b0;
    if (!ucpden) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            state_nx = ST_GAP;
            sel_nx   = req_top;
            mode_nx  = msg_mode;
          end
        end
        ST_GAP: begin
          if (!sel_live) begin
            state_nx = ST_IDLE;
          end else begin
            if (req_top > sel) sel_nx = req_top;
            if (sel_nx != SEL_HRST && rx_rise) begin
              state_nx    = ST_IDLE;
              msg_disc_nx = 1'b1;
              send_clr_nx = 1'b1;
            end else if (sel_nx == SEL_HRST && rx_hrst_det) begin
              state_nx     = ST_IDLE;
              hrst_disc_nx = 1'b1;
              hrst_clr_nx  = 1'b1;
            end else if (gap_cnt == '0 && !rx_busy) begin
              state_nx = ST_TX;
            end
          end
        end
        ST_TX: begin
          // Frame end beats a simultaneous preemption; the hard reset then queues normally.
          if (tx_done) begin
            state_nx    = ST_DONE;
            hrst_clr_nx = (sel == SEL_HRST);
            send_clr_nx = (sel != SEL_HRST);
`ifdef UCPD_TXARB_PREEMPT_EN
          end else if (hrst_rise && sel != SEL_HRST) begin
            state_nx    = ST_ABORT;
            msg_disc_nx = 1'b1;
            send_clr_nx = 1'b1;
`endif
          end
        end
`ifdef UCPD_TXARB_PREEMPT_EN
        ST_ABORT: begin
          state_nx = ST_TX;
          sel_nx   = SEL_HRST;
        end
`endif
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    en_nx      = (state_nx == ST_TX);
    tx_mode_nx = 2'b00;
    if (en_nx) begin
      if (sel_nx == SEL_CRST)     tx_mode_nx = 2'b01;
      else if (sel_nx == SEL_MSG) tx_mode_nx = mode_nx;
    end
  end

  // Gap counter: reloads on frame end or receive end, drains on bit-clock ticks.
  always_ff @(posedge ic_clk or posedge ic_rst) begin
    if (ic_rst) begin
      gap_cnt   <= '0;
      rx_busy_q <= 1'b0;
    end else begin
      rx_busy_q <= rx_busy;
      if (!ucpden)                          gap_cnt <= '0;
      else if (tx_done || rx_fall)          gap_cnt <= ifrgap;
      else if (bit_clk_red && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

`ifdef UCPD_TXARB_PREEMPT_EN
  always_ff @(posedge ic_clk or posedge ic_rst) begin
    if (ic_rst) hrst_req_q <= 1'b0;
    else        hrst_req_q <= hrst_req;
  end
`endif

  always_ff @(posedge ic_clk or posedge ic_rst) begin
    if (ic_rst) begin
      state       <= ST_IDLE;
      sel         <= SEL_MSG;
      mode_q      <= 2'b00;
      transmit_en <= 1'b0;
      tx_hrst     <= 1'b0;
      tx_mode     <= 2'b00;
      txsend_clr  <= 1'b0;
      txhrst_clr  <= 1'b0;
      msg_disc    <= 1'b0;
      hrst_disc   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      sel         <= sel_nx;
      mode_q      <= mode_nx;
      transmit_en <= en_nx;
      tx_hrst     <= en_nx && (sel_nx == SEL_HRST);
      tx_mode     <= tx_mode_nx;
      txsend_clr  <= send_clr_nx;
      txhrst_clr  <= hrst_clr_nx;
      msg_disc    <= msg_disc_nx;
      hrst_disc   <= hrst_disc_nx;
      busy        <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ucpd_tx_arbiter.sv
// Self-checking bench for ucpd_tx_arbiter: vector table plus frame/pulse scoreboard queues.
// Honours UCPD_TXARB_PREEMPT_EN for the preemption expectations.
module tb_ucpd_tx_arbiter;

  localparam int GAP_W = 5;
  // Pulse code: {hrst_disc, msg_disc, txhrst_clr, txsend_clr}
  localparam logic [3:0] P_SEND  = 4'b0001;
  localparam logic [3:0] P_HCLR  = 4'b0010;
  localparam logic [3:0] P_MDISC = 4'b0101;
  localparam logic [3:0] P_HDISC = 4'b1010;

  logic             ic_clk = 1'b0;
  logic             ic_rst, ucpden, hrst_req, crst_req, msg_req;
  logic [1:0]       msg_mode;
  logic [GAP_W-1:0] ifrgap;
  logic             bit_clk_red, rx_busy, rx_hrst_det, tx_done;
  logic             transmit_en, tx_hrst, txsend_clr, txhrst_clr, msg_disc, hrst_disc, busy;
  logic [1:0]       tx_mode;

  typedef struct {
    logic       hrst;
    logic [1:0] mode;
  } frame_t;

  typedef struct {
    logic       h, c, m;
    logic [1:0] mode;
    int         nfr;
    frame_t     f0, f1;
    logic [3:0] p0, p1;
  } vec_t;

  frame_t     exp_frames[$];
  logic [3:0] exp_pulses[$];
  vec_t       tbl[7];
  int         n_vec = 0;
  int         n_miss = 0;
  logic       prev_en = 1'b0;
  logic [3:0] prev_p = 4'b0;

  ucpd_tx_arbiter #(.GAP_W(GAP_W)) dut (
    .ic_clk(ic_clk), .ic_rst(ic_rst), .ucpden(ucpden),
    .hrst_req(hrst_req), .crst_req(crst_req), .msg_req(msg_req), .msg_mode(msg_mode),
    .ifrgap(ifrgap), .bit_clk_red(bit_clk_red), .rx_busy(rx_busy), .rx_hrst_det(rx_hrst_det),
    .tx_done(tx_done), .transmit_en(transmit_en), .tx_hrst(tx_hrst), .tx_mode(tx_mode),
    .txsend_clr(txsend_clr), .txhrst_clr(txhrst_clr), .msg_disc(msg_disc),
    .hrst_disc(hrst_disc), .busy(busy)
  );

  always #5 ic_clk = ~ic_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  function automatic vec_t mk(logic h, logic c, logic m, logic [1:0] mode, int nfr,
                              logic f0h, logic [1:0] f0m, logic f1h, logic [1:0] f1m,
                              logic [3:0] p0, logic [3:0] p1);
    vec_t v;
    v.h = h; v.c = c; v.m = m; v.mode = mode; v.nfr = nfr;
    v.f0.hrst = f0h; v.f0.mode = f0m; v.f1.hrst = f1h; v.f1.mode = f1m;
    v.p0 = p0; v.p1 = p1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic push_frame(input logic h, input logic [1:0] m);
    frame_t f;
    f.hrst = h; f.mode = m;
    exp_frames.push_back(f);
  endtask

  // One clock: sample at negedge, score frames and pulses, model the register block's clears.
  task automatic tick();
    frame_t     f;
    logic [3:0] p, e;
    @(negedge ic_clk);
    p = {hrst_disc, msg_disc, txhrst_clr, txsend_clr};
    if (transmit_en && !prev_en) begin
      if (exp_frames.size() == 0) checkOutput("unexpected_frame", transmit_en, 0);
      else begin
        f = exp_frames.pop_front();
        checkOutput("frame_tx_hrst", tx_hrst, f.hrst);
        checkOutput("frame_tx_mode", tx_mode, f.mode);
      end
    end
    if (p != 4'b0) begin
      checkOutput("pulse_width", p & prev_p, 0);
      if (exp_pulses.size() == 0) checkOutput("unexpected_pulse", p, 0);
      else begin
        e = exp_pulses.pop_front();
        checkOutput("pulse_kind", p, e);
      end
    end
    prev_en = transmit_en;
    prev_p  = p;
    if (txsend_clr) begin msg_req = 1'b0; crst_req = 1'b0; end
    if (txhrst_clr) hrst_req = 1'b0;
    tx_done = 1'b0; bit_clk_red = 1'b0; rx_hrst_det = 1'b0;
  endtask

  task automatic wait_en(input int max, output int lat);
    lat = 0;
    while (!transmit_en && lat < max) begin
      tick();
      lat++;
    end
    if (!transmit_en) checkOutput("en_timeout", transmit_en, 1);
  endtask

  task automatic finish_frame();
    tick(); tick();
    tx_done = 1'b1;
    tick();
    checkOutput("en_fall_after_done", transmit_en, 0);
    checkOutput("clr_with_en_fall", txsend_clr | txhrst_clr, 1);
    tick();
    checkOutput("idle_after_done", busy, 0);
  endtask

  task automatic load_gap(input logic [GAP_W-1:0] g);
    ifrgap = g; rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0;
    tick();
    ifrgap = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    hrst_req = v.h; crst_req = v.c; msg_req = v.m; msg_mode = v.mode;
    exp_frames.push_back(v.f0);
    exp_pulses.push_back(v.p0);
    if (v.nfr == 2) begin
      exp_frames.push_back(v.f1);
      exp_pulses.push_back(v.p1);
    end
  endtask

  initial begin
    int lat, nt, c5, ce;
    logic set;

    tbl[0] = mk(0, 0, 1, 2'b00, 1, 0, 2'b00, 0, 2'b00, P_SEND, 4'b0);
    tbl[1] = mk(0, 0, 1, 2'b10, 1, 0, 2'b10, 0, 2'b00, P_SEND, 4'b0);
    tbl[2] = mk(0, 1, 0, 2'b00, 1, 0, 2'b01, 0, 2'b00, P_SEND, 4'b0);
    tbl[3] = mk(1, 0, 0, 2'b10, 1, 1, 2'b00, 0, 2'b00, P_HCLR, 4'b0);
    tbl[4] = mk(0, 1, 1, 2'b10, 1, 0, 2'b01, 0, 2'b00, P_SEND, 4'b0);
    tbl[5] = mk(1, 1, 1, 2'b00, 2, 1, 2'b00, 0, 2'b01, P_HCLR, P_SEND);
    tbl[6] = mk(1, 0, 1, 2'b10, 2, 1, 2'b00, 0, 2'b10, P_HCLR, P_SEND);

    ic_rst = 1'b1; ucpden = 1'b1; hrst_req = 0; crst_req = 0; msg_req = 0; msg_mode = 2'b00;
    ifrgap = '0; bit_clk_red = 0; rx_busy = 0; rx_hrst_det = 0; tx_done = 0;
    repeat (2) @(negedge ic_clk);
    checkOutput("reset_outputs",
                {transmit_en, tx_hrst, tx_mode, txsend_clr, txhrst_clr, msg_disc, hrst_disc, busy}, 0);
    ic_rst = 1'b0;
    tick();
    checkOutput("reset_release_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i]);
      wait_en(20, lat);
      checkOutput("grant_latency", lat, 2);
      finish_frame();
      if (tbl[i].nfr == 2) begin
        wait_en(20, lat);
        finish_frame();
      end
      tick();
      checkOutput("vec_idle", busy, 0);
    end

    // Interframe gap of 5 ticks loaded by the previous frame's tx_done.
    push_frame(0, 2'b00); exp_pulses.push_back(P_SEND);
    ifrgap = 5'd5; msg_req = 1'b1; msg_mode = 2'b00;
    wait_en(20, lat);
    tick();
    tx_done = 1'b1;
    tick();
    msg_req = 1'b1; ifrgap = '0;
    push_frame(0, 2'b00); exp_pulses.push_back(P_SEND);
    nt = 0; c5 = -1; ce = -1;
    for (int c = 0; c < 60; c++) begin
      set = (c % 3 == 2);
      bit_clk_red = set;
      tick();
      if (set) begin
        nt++;
        if (nt == 5) c5 = c;
      end
      if (transmit_en) begin
        ce = c;
        break;
      end
    end
    checkOutput("gap_ticks_before_en", nt, 5);
    checkOutput("gap_en_cycle", ce, c5 + 1);
    finish_frame();

    // Receive activity starting during the gap discards the message.
    load_gap(5'd3);
    msg_req = 1'b1;
    tick(); tick();
    checkOutput("gap_hold_busy", busy, 1);
    checkOutput("gap_hold_en", transmit_en, 0);
    exp_pulses.push_back(P_MDISC);
    rx_busy = 1'b1;
    tick();
    checkOutput("rx_disc_msg_disc", msg_disc, 1);
    tick();
    checkOutput("rx_disc_idle", busy, 0);
    rx_busy = 1'b0;
    tick();

    // Received hard reset during the gap discards a pending hard reset.
    load_gap(5'd3);
    hrst_req = 1'b1;
    tick(); tick();
    exp_pulses.push_back(P_HDISC);
    rx_hrst_det = 1'b1;
    tick();
    checkOutput("hrst_disc_pulse", hrst_disc, 1);
    tick();
    checkOutput("hrst_disc_idle", busy, 0);
    load_gap('0);

    // Request withdrawn mid-gap: back to idle silently.
    load_gap(5'd3);
    crst_req = 1'b1;
    tick(); tick();
    crst_req = 1'b0;
    tick();
    checkOutput("req_drop_idle", busy, 0);
    load_gap('0);

    // Block disable mid-gap: idle, no pulses, gap counter cleared.
    load_gap(5'd3);
    msg_req = 1'b1;
    tick(); tick();
    ucpden = 1'b0;
    tick();
    checkOutput("ucpden_idle", busy, 0);
    tick();
    ucpden = 1'b1;
    push_frame(0, 2'b00); exp_pulses.push_back(P_SEND);
    wait_en(20, lat);
    checkOutput("ucpden_cnt_cleared_lat", lat, 2);
    finish_frame();

    // Hard reset raised during a message frame.
    push_frame(0, 2'b00);
`ifdef UCPD_TXARB_PREEMPT_EN
    exp_pulses.push_back(P_MDISC);
`else
    exp_pulses.push_back(P_SEND);
`endif
    push_frame(1, 2'b00); exp_pulses.push_back(P_HCLR);
    msg_req = 1'b1; msg_mode = 2'b00;
    wait_en(20, lat);
    tick();
    hrst_req = 1'b1;
    tick();
`ifdef UCPD_TXARB_PREEMPT_EN
    checkOutput("abort_en_low", transmit_en, 0);
    checkOutput("abort_msg_disc", msg_disc, 1);
    tick();
    checkOutput("abort_then_en", transmit_en, 1);
    checkOutput("abort_then_tx_hrst", tx_hrst, 1);
    finish_frame();
`else
    checkOutput("no_preempt_en", transmit_en, 1);
    checkOutput("no_preempt_tx_hrst", tx_hrst, 0);
    finish_frame();
    wait_en(20, lat);
    checkOutput("hrst_after_gap_tx_hrst", tx_hrst, 1);
    finish_frame();
`endif

    // tx_done coinciding with a new hard reset: message completes, hard reset follows.
    push_frame(0, 2'b10); exp_pulses.push_back(P_SEND);
    push_frame(1, 2'b00); exp_pulses.push_back(P_HCLR);
    msg_req = 1'b1; msg_mode = 2'b10;
    wait_en(20, lat);
    tick();
    hrst_req = 1'b1; tx_done = 1'b1;
    tick();
    checkOutput("simul_done_en", transmit_en, 0);
    checkOutput("simul_done_send_clr", txsend_clr, 1);
    wait_en(20, lat);
    checkOutput("simul_hrst_lat", lat, 3);
    finish_frame();

    // Asynchronous reset in the middle of a frame.
    push_frame(0, 2'b10);
    msg_req = 1'b1; msg_mode = 2'b10;
    wait_en(20, lat);
    tick();
    #2 ic_rst = 1'b1;
    #1;
    checkOutput("async_rst_en", transmit_en, 0);
    checkOutput("async_rst_mode", tx_mode, 0);
    checkOutput("async_rst_busy", busy, 0);
    msg_req = 1'b0;
    tick();
    ic_rst = 1'b0;
    tick(); tick();
    checkOutput("post_rst_idle", busy, 0);

    checkOutput("frames_left", exp_frames.size(), 0);
    checkOutput("pulses_left", exp_pulses.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ucpd_tx_arbiter.md
# ucpd_tx_arbiter

Transmit scheduler for the UCPD core. Arbitrates between three transmit requesters (hard reset, cable reset, normal message) and ongoing receive activity. Enforces the interframe gap in bit-clock ticks, then drives the core's `transmit_en`, `tx_hrst` and `tx_mode` for exactly one frame. Issues the register clear and discard pulses back to the register block.

## Interface
Parameters:
- `GAP_W`, 5: width of the interframe-gap counter; matches `ifrgap`.

Ports:
- `ic_clk` in 1: block clock (HSI16); the only clock.
- `ic_rst` in 1: reset, asynchronous, active-high.
- `ucpden` in 1: block enable; low forces IDLE.
- `hrst_req` in 1: hard-reset request level, held until `txhrst_clr`.
- `crst_req` in 1: cable-reset request level, held until `txsend_clr`.
- `msg_req` in 1: message request level, held until `txsend_clr`.
- `msg_mode` in 2: message `tx_mode` (00 normal, 10 BIST); latched at grant.
- `ifrgap` in GAP_W: interframe gap in bit-clock ticks; 0 = no gap.
- `bit_clk_red` in 1: one-cycle bit-clock tick.
- `rx_busy` in 1: receiver active (`receive_en`).
- `rx_hrst_det` in 1: received hard reset (`hrst_vld`), pulse.
- `tx_done` in 1: frame end from core (`tx_eop_cmplt`), pulse.
- `transmit_en` out 1: frame transmit enable to core.
- `tx_hrst` out 1: current frame is a hard reset.
- `tx_mode` out 2: mode for current frame.
- `txsend_clr` out 1: pulse; clears msg/crst request.
- `txhrst_clr` out 1: pulse; clears hrst request.
- `msg_disc` out 1: pulse; message/cable reset discarded.
- `hrst_disc` out 1: pulse; hard reset discarded.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, GAP, TX, ABORT, DONE. Reset: IDLE, counter 0, all outputs 0.
- Priority: hrst > crst > msg. The selected source `sel` is latched on leaving IDLE.
- Gap counter:
  - loads `ifrgap` on `tx_done` and on the `rx_busy` falling edge;
  - decrements on `bit_clk_red` while nonzero;
  - saturates at 0.
- IDLE: any request and `ucpden` → GAP, `sel` latched.
- GAP:
  - counter == 0 and `rx_busy` == 0 → TX.
  - `rx_busy` rises with `sel` = msg/crst → `msg_disc` + `txsend_clr`, → IDLE.
  - `rx_hrst_det` with `sel` = hrst → `hrst_disc` + `txhrst_clr`, → IDLE.
  - A higher-priority request arriving in GAP replaces `sel` with no pulse.
- TX:
  - `transmit_en` = 1.
  - `tx_hrst` = (`sel` == hrst).
  - `tx_mode` = 01 for crst, latched `msg_mode` for msg, 00 for hrst.
  - `tx_done` → DONE.
- DONE (1 cycle): `txhrst_clr` if `sel` = hrst, else `txsend_clr` → IDLE.
- ABORT (1 cycle, preemption only):
  - `transmit_en` = 0;
  - `msg_disc` + `txsend_clr`;
  - `sel` = hrst → TX; the gap is bypassed for a preempting hard reset.
- `ucpden` low in any state: → IDLE next cycle, outputs 0, no clear/discard pulses, counter cleared.
- Requests dropped by software mid-GAP: → IDLE, no pulses. Requests dropped in TX are ignored.
- Simultaneous `tx_done` and preemption: `tx_done` wins (DONE), and hrst is then scheduled normally through the gap.

## Timing
- Grant latency:
  - request seen in IDLE at cycle N → GAP at N+1;
  - `transmit_en` high at N+2 if the gap is 0 and `rx_busy` is low.
- All outputs are registered; clear/discard pulses are exactly 1 cycle wide.
- `transmit_en` falls the cycle after `tx_done` is sampled.
- `txsend_clr`/`txhrst_clr` are high in that same cycle.
- Gap of G ticks: `transmit_en` no earlier than 1 cycle after the G-th `bit_clk_red` following the load event.

## Configuration
- `UCPD_TXARB_PREEMPT_EN` defined: `hrst_req` rising during TX of msg/crst → ABORT → TX with hard reset; `transmit_en` low for exactly 1 cycle between frames.
- Undefined: no ABORT state. A hard reset raised during TX waits for `tx_done`, then goes through GAP like any request.

## Test plan
- `msg_req`=1, `msg_mode`=00, `ifrgap`=0, `rx_busy`=0 → `transmit_en` at req+2; `tx_done` → `txsend_clr` 1-cycle pulse next cycle; IDLE.
- `ifrgap`=5 after a `tx_done`, `msg_req` held → `transmit_en` stays 0 until 1 cycle after the 5th `bit_clk_red`.
- `hrst_req`, `crst_req`, `msg_req` all 1 in IDLE → first frame has `tx_hrst`=1; then `tx_mode`=01; `txhrst_clr` before `txsend_clr`.
- `msg_req` in GAP, `rx_busy` rises → `msg_disc` and `txsend_clr` 1 cycle; `transmit_en` never asserted.
- With `UCPD_TXARB_PREEMPT_EN`, `hrst_req` mid-message TX:
  - `transmit_en` 0 for 1 cycle, with `msg_disc`;
  - then `transmit_en`=1 with `tx_hrst`=1;
  - without the macro, the hard reset follows `tx_done` and the gap.
- `ic_rst` asserted mid-TX → all outputs 0 immediately (asynchronous); IDLE after release. `ucpden` low mid-GAP → IDLE, no pulses.
